// File: rtl/tlp_pkg.sv
// rtl/tlp_pkg.sv - shared TLP header constants, TX state enum and header builders
//
// Contents:
//   FMT_3DW_WD  fmt field for a 3DW header with data
//   TYPE_MEM    type field for memory requests
//   state_e     TX framer state (IDLE, REQ, HDR0, HDR1, DATA, LAST)
//   mk_dw0      header DW0 for a MWr of the given DW length (1024 encodes as 0)
//   mk_dw1      header DW1 {requester id, tag, last BE, first BE}
package tlp_pkg;

  localparam logic [1:0] FMT_3DW_WD = 2'b10;
  localparam logic [4:0] TYPE_MEM   = 5'b00000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_LAST
  } state_e;

  // {R, fmt, type, R, TC, R, attr, R, TH, TD, EP, attr, AT, length}; all
  // optional fields are zero, so only fmt/type/length are non-zero.
  function automatic logic [31:0] mk_dw0(input logic [9:0] len);
    return {1'b0, FMT_3DW_WD, TYPE_MEM, 14'd0, len};
  endfunction

  function automatic logic [31:0] mk_dw1(input logic [15:0] rid,
                                         input logic [7:0]  tag,
                                         input logic [3:0]  lbe,
                                         input logic [3:0]  fbe);
    return {rid, tag, lbe, fbe};
  endfunction

endpackage

// File: rtl/tlp_mwr_tx_if.sv
// rtl/tlp_mwr_tx_if.sv - 64-bit AXI4-Stream TX beat interface toward the PCIe core
//
// Signals:
//   enc_tx_tdata   64  stream data
//   enc_tx_tstrb   8   byte strobes
//   enc_tx_tvalid  1   beat valid
//   enc_tx_tlast   1   last beat of TLP
//   enc_tx_tready  1   core accepts beat
// Modports: master (TLP source), slave (PCIe core side).
interface tlp_mwr_tx_if;

  logic [63:0] enc_tx_tdata;
  logic [7:0]  enc_tx_tstrb;
  logic        enc_tx_tvalid;
  logic        enc_tx_tlast;
  logic        enc_tx_tready;

  modport master (
    output enc_tx_tdata,
    output enc_tx_tstrb,
    output enc_tx_tvalid,
    output enc_tx_tlast,
    input  enc_tx_tready
  );

  modport slave (
    input  enc_tx_tdata,
    input  enc_tx_tstrb,
    input  enc_tx_tvalid,
    input  enc_tx_tlast,
    output enc_tx_tready
  );

endinterface

// File: rtl/tlp_addr_gen.sv
// rtl/tlp_addr_gen.sv - destination address and tag counters for the MWr framer
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   tx_en_i      DMA enable; low while idle reloads address and tag
//   idle_i       framer is in IDLE (reload only allowed between TLPs)
//   adv_i        LAST beat transferred: step address, bump tag
//   base_i       ring base address (DW aligned)
//   size_i       ring size in bytes
//   addr_o       address for the next/current TLP
//   tag_o        tag for the next/current TLP
module tlp_addr_gen #(
  parameter logic [31:0] STEP = 32'd128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_en_i,
  input  logic        idle_i,
  input  logic        adv_i,
  input  logic [31:0] base_i,
  input  logic [31:0] size_i,
  output logic [31:0] addr_o,
  output logic [7:0]  tag_o
);

  logic [31:0] addr_q, addr_d;
  logic [7:0]  tag_q, tag_d;
  logic [31:0] addr_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= base_i;
      tag_q  <= 8'd0;
    end else begin
      addr_q <= addr_d;
      tag_q  <= tag_d;
    end
  end

  always_comb begin
    addr_d   = addr_q;
    tag_d    = tag_q;
    addr_nxt = addr_q + STEP;
    if (adv_i) begin
      // Offset of the next TLP from base reaching the ring size means the
      // ring is exhausted; restart at base.
      addr_d = ((addr_nxt - base_i) >= size_i) ? base_i : addr_nxt;
      tag_d  = tag_q + 8'd1;
    end else if (idle_i && !tx_en_i) begin
      addr_d = base_i;
      tag_d  = 8'd0;
    end
  end

  assign addr_o = addr_q;
  assign tag_o  = tag_q;

endmodule

// File: rtl/tlp_mwr_tx.sv
// rtl/tlp_mwr_tx.sv - posted Memory Write TLP generator draining a 64-bit FWFT FIFO
//
// Optional feature macro: TLP_MWR_TX_STATS_EN (adds tlp_cnt / dw_cnt outputs).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   lnk_up, tx_en       start gating (only sampled in IDLE)
//   dma_base_addr/size  destination ring
//   requester_id        header DW1 requester id
//   fifo_rd_data/empty/level, fifo_rd_en   FWFT FIFO read side
//   tx_req / tx_gnt     TX bus arbitration
//   tx                  stream toward the PCIe core (tlp_mwr_tx_if.master)
//   busy                TLP in progress
//   tlp_cnt, dw_cnt     (stats build only) completed TLPs / payload DWs
module tlp_mwr_tx
  import tlp_pkg::*;
#(
  parameter int PAYLOAD_DW = 32,
  parameter int LVL_W      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lnk_up,
  input  logic             tx_en,
  input  logic [31:0]      dma_base_addr,
  input  logic [31:0]      dma_size,
  input  logic [15:0]      requester_id,
  input  logic [63:0]      fifo_rd_data,
  input  logic             fifo_empty,
  input  logic [LVL_W-1:0] fifo_level,
  output logic             fifo_rd_en,
  output logic             tx_req,
  input  logic             tx_gnt,
  tlp_mwr_tx_if.master     tx,
  output logic             busy
`ifdef TLP_MWR_TX_STATS_EN
  ,
  output logic [31:0]      tlp_cnt,
  output logic [31:0]      dw_cnt
`endif
);

  localparam int               NDATA     = PAYLOAD_DW / 2 - 1;
  localparam logic [6:0]       DATA_LAST = 7'(NDATA - 1);
  localparam logic [LVL_W-1:0] MIN_LVL   = LVL_W'(PAYLOAD_DW / 2);
  localparam logic [9:0]       LEN       = 10'(PAYLOAD_DW);

  state_e      state_q, state_d;
  logic [31:0] carry_q, carry_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        adv;
  logic [31:0] addr;
  logic [7:0]  tag;

  tlp_addr_gen #(
    .STEP (32'(PAYLOAD_DW * 4))
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .tx_en_i (tx_en),
    .idle_i  (state_q == ST_IDLE),
    .adv_i   (adv),
    .base_i  (dma_base_addr),
    .size_i  (dma_size),
    .addr_o  (addr),
    .tag_o   (tag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      carry_q <= 32'd0;
      cnt_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Beats are built combinationally from state, carry and the FWFT head, so
  // they stay stable under backpressure without extra holding registers.
  always_comb begin
    state_d          = state_q;
    carry_d          = carry_q;
    cnt_d            = cnt_q;
    tx_req           = 1'b0;
    fifo_rd_en       = 1'b0;
    adv              = 1'b0;
    tx.enc_tx_tvalid = 1'b0;
    tx.enc_tx_tdata  = 64'd0;
    tx.enc_tx_tstrb  = 8'h00;
    tx.enc_tx_tlast  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_en && lnk_up && (fifo_level >= MIN_LVL)) state_d = ST_REQ;
      end
      ST_REQ: begin
        tx_req = 1'b1;
        if (tx_gnt) state_d = ST_HDR0;
      end
      ST_HDR0: begin
        tx_req           = 1'b1;
        tx.enc_tx_tvalid = 1'b1;
        tx.enc_tx_tdata  = {mk_dw1(requester_id, tag, 4'hF, 4'hF), mk_dw0(LEN)};
        tx.enc_tx_tstrb  = 8'hFF;
        if (tx.enc_tx_tready) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        tx_req           = 1'b1;
        tx.enc_tx_tvalid = !fifo_empty;
        tx.enc_tx_tdata  = {fifo_rd_data[31:0], addr};
        tx.enc_tx_tstrb  = 8'hFF;
        if (!fifo_empty && tx.enc_tx_tready) begin
          fifo_rd_en = 1'b1;
          carry_d    = fifo_rd_data[63:32];
          cnt_d      = 7'd0;
          state_d    = (NDATA == 0) ? ST_LAST : ST_DATA;
        end
      end
      ST_DATA: begin
        tx_req           = 1'b1;
        tx.enc_tx_tvalid = !fifo_empty;
        tx.enc_tx_tdata  = {fifo_rd_data[31:0], carry_q};
        tx.enc_tx_tstrb  = 8'hFF;
        if (!fifo_empty && tx.enc_tx_tready) begin
          fifo_rd_en = 1'b1;
          carry_d    = fifo_rd_data[63:32];
          cnt_d      = cnt_q + 7'd1;
          if (cnt_q == DATA_LAST) state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        tx_req           = 1'b1;
        tx.enc_tx_tvalid = 1'b1;
        tx.enc_tx_tdata  = {32'h0, carry_q};
        tx.enc_tx_tstrb  = 8'h0F;
        tx.enc_tx_tlast  = 1'b1;
        if (tx.enc_tx_tready) begin
          adv     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

`ifdef TLP_MWR_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tlp_cnt <= 32'd0;
      dw_cnt  <= 32'd0;
    end else if (adv) begin
      tlp_cnt <= tlp_cnt + 32'd1;
      dw_cnt  <= dw_cnt + 32'(PAYLOAD_DW);
    end
  end
`endif

endmodule

// File: tb/tb_tlp_mwr_tx.sv
// tb/tb_tlp_mwr_tx.sv - scoreboard testbench for tlp_mwr_tx (PAYLOAD_DW=4)
module tb_tlp_mwr_tx;

  localparam int PDW = 4;
  localparam int NW  = PDW / 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lnk_up = 1'b0;
  logic        tx_en = 1'b0;
  logic [31:0] dma_base_addr = 32'h0000_1000;
  logic [31:0] dma_size = 32'd32;
  logic [15:0] requester_id = 16'h01A0;
  logic [63:0] fifo_rd_data;
  logic        fifo_empty;
  logic [9:0]  fifo_level;
  logic        fifo_rd_en;
  logic        tx_req;
  logic        tx_gnt = 1'b1;
  logic        busy;
`ifdef TLP_MWR_TX_STATS_EN
  logic [31:0] tlp_cnt, dw_cnt;
`endif

  tlp_mwr_tx_if tx();

  tlp_mwr_tx #(.PAYLOAD_DW(PDW), .LVL_W(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .lnk_up        (lnk_up),
    .tx_en         (tx_en),
    .dma_base_addr (dma_base_addr),
    .dma_size      (dma_size),
    .requester_id  (requester_id),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_empty    (fifo_empty),
    .fifo_level    (fifo_level),
    .fifo_rd_en    (fifo_rd_en),
    .tx_req        (tx_req),
    .tx_gnt        (tx_gnt),
    .tx            (tx.master),
    .busy          (busy)
`ifdef TLP_MWR_TX_STATS_EN
    ,
    .tlp_cnt       (tlp_cnt),
    .dw_cnt        (dw_cnt)
`endif
  );

  always #5 clk = ~clk;

  // FWFT FIFO model
  logic [63:0] mem [0:63];
  logic [6:0]  wr_ptr = 7'd0;
  logic [6:0]  rd_ptr = 7'd0;
  logic        pop_seen;
  assign fifo_rd_data = mem[rd_ptr[5:0]];
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_level   = {3'b000, wr_ptr - rd_ptr};

  always begin
    @(negedge clk);
    pop_seen = fifo_rd_en;
    @(posedge clk);
    #1;
    if (pop_seen) rd_ptr = rd_ptr + 7'd1;
  end

  int checks = 0;
  int errors = 0;
  int mrd = 0;
  int n_full = 0;
  logic [72:0] exp_q [$];

  // Monitor: compares every transferred beat, and the stalled beat against
  // the head of the queue so held data is verified too.
  always @(negedge clk) begin
    logic [72:0] got, want;
    if (!reset && tx.enc_tx_tvalid) begin
      got = {tx.enc_tx_tdata, tx.enc_tx_tstrb, tx.enc_tx_tlast};
      if (tx.enc_tx_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat unexpected: got %h", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL beat: got data=%h strb=%h last=%b want data=%h strb=%h last=%b",
                     got[72:9], got[8:1], got[0], want[72:9], want[8:1], want[0]);
          end
        end
      end else if (exp_q.size() != 0) begin
        checks++;
        if (got !== exp_q[0]) begin
          errors++;
          $display("FAIL stall_hold: got %h want %h", got, exp_q[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic push_word(input logic [63:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 7'd1;
  endtask

  task automatic push_exp(input logic [63:0] d, input logic [7:0] s, input logic l);
    exp_q.push_back({d, s, l});
  endtask

  // Expected TLP from the bench's copy of the FIFO contents; trunc keeps only
  // the two header beats (the TLP gets cut by reset afterwards).
  task automatic exp_tlp(input logic [31:0] a, input logic [7:0] t, input bit trunc);
    logic [63:0] w;
    logic [31:0] c;
    push_exp({requester_id, t, 8'hFF, 32'h4000_0000 | PDW}, 8'hFF, 1'b0);
    w = mem[mrd[5:0]]; mrd++;
    push_exp({w[31:0], a}, 8'hFF, 1'b0);
    c = w[63:32];
    if (!trunc) begin
      for (int k = 1; k < NW; k++) begin
        w = mem[mrd[5:0]]; mrd++;
        push_exp({w[31:0], c}, 8'hFF, 1'b0);
        c = w[63:32];
      end
      push_exp({32'h0, c}, 8'h0F, 1'b1);
      n_full++;
    end
  endtask

  task automatic beats(input int n, input int stall);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!tx.enc_tx_tvalid && w < 50) begin tick(); w++; end
      if (w == 50) begin
        errors++;
        $display("FAIL beat_timeout: got tvalid=0 want tvalid=1");
      end
      repeat (stall) tick();
      tx.enc_tx_tready = 1'b1;
      tick();
      tx.enc_tx_tready = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int w = 0;
    while ((exp_q.size() != 0 || busy) && w < 300) begin tick(); w++; end
    chk(name, 128'(w < 300), 128'd1);
  endtask

  task automatic expect_no_req(input string name, input int n);
    bit ok = 1'b1;
    repeat (n) begin
      tick();
      if (tx_req || busy || tx.enc_tx_tvalid) ok = 1'b0;
    end
    chk(name, 128'(ok), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tx.enc_tx_tready = 1'b0;
    repeat (3) tick();
    chk("reset_outputs",
        {tx.enc_tx_tdata, tx.enc_tx_tstrb, tx.enc_tx_tvalid, tx.enc_tx_tlast, tx_req, fifo_rd_en, busy},
        128'd0);
    reset = 1'b0;
    tx_en = 1'b1;
    lnk_up = 1'b1;

    // basic TLP, hand-computed beats
    push_word(64'hB4A3A2B1_0FC4D8A5);
    push_word(64'h11223344_55667788);
    push_exp(64'h01A000FF_40000004, 8'hFF, 1'b0);
    push_exp(64'h0FC4D8A5_00001000, 8'hFF, 1'b0);
    push_exp(64'h55667788_B4A3A2B1, 8'hFF, 1'b0);
    push_exp(64'h00000000_11223344, 8'h0F, 1'b1);
    mrd = 2; n_full = 1;
    beats(4, 0);
    wait_done("basic_done");
    tick();
    chk("basic_pops", 128'(rd_ptr), 128'd2);

    // backpressure: 3 stalled cycles per beat
    push_word(64'hCAFE0001_BEEF0001);
    push_word(64'hCAFE0002_BEEF0002);
    exp_tlp(32'h0000_1010, 8'd1, 1'b0);
    beats(4, 3);
    wait_done("bp_done");
    tick();
    chk("bp_pops", 128'(rd_ptr), 128'd4);

    // tx_en low in IDLE: no request, address/tag reload; then ring wrap
    tx_en = 1'b0;
    for (int i = 0; i < 8; i++) push_word({32'hD000_0000 + 32'(i), 32'h7000_0000 + 32'(i)});
    expect_no_req("gate_tx_en", 5);
    exp_tlp(32'h0000_1000, 8'd0, 1'b0);
    exp_tlp(32'h0000_1010, 8'd1, 1'b0);
    exp_tlp(32'h0000_1000, 8'd2, 1'b0);
    exp_tlp(32'h0000_1010, 8'd3, 1'b0);
    tx.enc_tx_tready = 1'b1;
    tx_en = 1'b1;
    wait_done("ring_done");
    tx.enc_tx_tready = 1'b0;

    // level gating: empty, then one word below threshold, then lnk_up low
    expect_no_req("gate_level0", 5);
    push_word(64'h0BAD0001_600D0001);
    expect_no_req("gate_level1", 5);
    lnk_up = 1'b0;
    push_word(64'h0BAD0002_600D0002);
    expect_no_req("gate_lnk_up", 5);

    // grant withheld: request but no beats
    tx_gnt = 1'b0;
    lnk_up = 1'b1;
    exp_tlp(32'h0000_1000, 8'd4, 1'b0);
    begin
      bit ok = 1'b1;
      tick();
      repeat (5) begin
        tick();
        if (tx.enc_tx_tvalid || !tx_req) ok = 1'b0;
      end
      chk("gnt_hold", 128'(ok), 128'd1);
    end
    tx_gnt = 1'b1;
    tx.enc_tx_tready = 1'b1;
    wait_done("gnt_done");
    tx.enc_tx_tready = 1'b0;

    // tx_en and lnk_up dropped mid-TLP: TLP completes, then reload
    dma_size = 32'd64;
    push_word(64'hE0000001_F0000001);
    push_word(64'hE0000002_F0000002);
    exp_tlp(32'h0000_1010, 8'd5, 1'b0);
    beats(1, 0);
    tx_en = 1'b0;
    lnk_up = 1'b0;
    beats(3, 0);
    wait_done("txen_drop_done");
    push_word(64'hE0000003_F0000003);
    push_word(64'hE0000004_F0000004);
    expect_no_req("txen_off_idle", 3);
    exp_tlp(32'h0000_1000, 8'd0, 1'b0);
    tx_en = 1'b1;
    lnk_up = 1'b1;
    tx.enc_tx_tready = 1'b1;
    wait_done("reload_done");
    tx.enc_tx_tready = 1'b0;
`ifdef TLP_MWR_TX_STATS_EN
    chk("stats_tlp_pre", 128'(tlp_cnt), 128'(n_full));
    chk("stats_dw_pre", 128'(dw_cnt), 128'(n_full * PDW));
`endif

    // reset during the DATA beat
    push_word(64'h9A000001_9B000001);
    push_word(64'h9A000002_9B000002);
    exp_tlp(32'h0000_1010, 8'd1, 1'b1);
    beats(2, 0);
    chk("pre_reset_busy", 128'(busy), 128'd1);
    reset = 1'b1;
    tick();
    chk("mid_reset_outputs",
        {tx.enc_tx_tdata, tx.enc_tx_tstrb, tx.enc_tx_tvalid, tx.enc_tx_tlast, tx_req, fifo_rd_en, busy},
        128'd0);
    reset = 1'b0;
    n_full = 0;
    push_word(64'h9A000003_9B000003);
    exp_tlp(32'h0000_1000, 8'd0, 1'b0);
    tx.enc_tx_tready = 1'b1;
    wait_done("post_reset_done");
    tx.enc_tx_tready = 1'b0;
    tick();
    chk("total_pops", 128'(rd_ptr), 128'(mrd));
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
`ifdef TLP_MWR_TX_STATS_EN
    chk("stats_tlp", 128'(tlp_cnt), 128'(n_full));
    chk("stats_dw", 128'(dw_cnt), 128'(n_full * PDW));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
